// File: rtl/ddr_rsp_pkg.sv
// rtl/ddr_rsp_pkg.sv - shared encodings, widths and FSM state types for the DDR AXI4 responder
package ddr_rsp_pkg;

    localparam int DATA_W = 512;
    localparam int STRB_W = 64;
    localparam int IDX_W  = 58;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [2:0] SIZE_64B   = 3'd6;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

    // Word index is compared at full width so bursts never alias back into memory.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int depth);
        return idx < IDX_W'(depth);
    endfunction

endpackage

// File: rtl/ddr_rsp_mem.sv
// rtl/ddr_rsp_mem.sv - simple dual-port 512-bit word memory, byte enables, read-first, registered read
module ddr_rsp_mem
    import ddr_rsp_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [STRB_W-1:0] wr_strb_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Both ports update with non-blocking writes, so a colliding read sees the old word.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
        if (wr_en_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ddr_axi4_responder.sv
// rtl/ddr_axi4_responder.sv - AXI4 slave responder with independent write and read FSMs over local memory
module ddr_axi4_responder
    import ddr_rsp_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ID_W      = 16
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,

    input  logic [ID_W-1:0]   s_awid,
    input  logic [63:0]       s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,

    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,

    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,

    input  logic [ID_W-1:0]   s_arid,
    input  logic [63:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,

    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready
);

    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    wr_state_t         wr_state_q;
    logic [ID_W-1:0]   wr_id_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [7:0]        wr_len_q;
    logic [7:0]        wr_cnt_q;
    logic              wr_err_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    rd_state_t         rd_state_q;
    logic [ID_W-1:0]   rd_id_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [7:0]        rd_len_q;
    logic [7:0]        rd_cnt_q;
    logic              rd_cfg_err_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [ID_W-1:0]   rid_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic              rd_zero_q;

    logic              wr_hs;
    logic              wr_in_range;
    logic              wr_last;
    logic              wr_beat_err;
    logic              mem_we;
    logic              mem_re;
    logic              rd_beat_err;
    logic [DATA_W-1:0] mem_rdata;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[5:0], s_araddr[5:0]};

    assign wr_hs       = (wr_state_q == W_DATA) && s_wvalid && wready_q;
    assign wr_in_range = idx_in_range(wr_idx_q, MEM_DEPTH);
    assign wr_last     = (wr_cnt_q == wr_len_q);
    assign wr_beat_err = !wr_in_range || (s_wlast != wr_last);
    assign mem_we      = wr_hs && wr_in_range;

    assign mem_re      = (rd_state_q == R_FETCH);
    assign rd_beat_err = rd_cfg_err_q || !idx_in_range(rd_idx_q, MEM_DEPTH);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_state_q <= W_IDLE;
            wr_id_q    <= '0;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_awvalid && awready_q) begin
                        wr_id_q    <= s_awid;
                        wr_idx_q   <= s_awaddr[63:6];
                        wr_len_q   <= s_awlen;
                        wr_cnt_q   <= '0;
                        wr_err_q   <= (s_awsize != SIZE_64B) || (s_awburst != BURST_INCR);
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    // awlen alone decides the end of the burst; wlast only feeds the error flag.
                    if (wr_hs) begin
                        wr_idx_q <= wr_idx_q + IDX_W'(1);
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                        wr_err_q <= wr_err_q | wr_beat_err;
                        if (wr_last) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bid_q      <= wr_id_q;
                            bresp_q    <= (wr_err_q | wr_beat_err) ? SLVERR : OKAY;
                            wr_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_state_q   <= R_IDLE;
            rd_id_q      <= '0;
            rd_idx_q     <= '0;
            rd_len_q     <= '0;
            rd_cnt_q     <= '0;
            rd_cfg_err_q <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rid_q        <= '0;
            rresp_q      <= OKAY;
            rlast_q      <= 1'b0;
            rd_zero_q    <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_arvalid && arready_q) begin
                        rd_id_q      <= s_arid;
                        rd_idx_q     <= s_araddr[63:6];
                        rd_len_q     <= s_arlen;
                        rd_cnt_q     <= '0;
                        rd_cfg_err_q <= (s_arsize != SIZE_64B) || (s_arburst != BURST_INCR);
                        arready_q    <= 1'b0;
                        rd_state_q   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid_q   <= 1'b1;
                    rid_q      <= rd_id_q;
                    rlast_q    <= (rd_cnt_q == rd_len_q);
                    rresp_q    <= rd_beat_err ? SLVERR : OKAY;
                    rd_zero_q  <= rd_beat_err;
                    rd_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (s_rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_idx_q   <= rd_idx_q + IDX_W'(1);
                            rd_cnt_q   <= rd_cnt_q + 8'd1;
                            rd_state_q <= R_FETCH;
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    ddr_rsp_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i     (clk_main_a0),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_idx_q[ADDR_W-1:0]),
        .wr_data_i (s_wdata),
        .wr_strb_i (s_wstrb),
        .rd_en_i   (mem_re),
        .rd_addr_i (rd_idx_q[ADDR_W-1:0]),
        .rd_data_o (mem_rdata)
    );

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rid     = rid_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = rlast_q;
    // The memory output register is unreset, so mask it whenever no good beat is presented.
    assign s_rdata   = (rvalid_q && !rd_zero_q) ? mem_rdata : '0;

endmodule

// File: doc/ddr_axi4_responder.md
DDR_AXI4_RESPONDER -- requirements
Module: ddr_axi4_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256: number of 512-bit words in local memory; power of two, 2..4096.
REQ-002 SHALL have parameter ID_W, default 16: AXI ID width.
REQ-003 SHALL have port clk_main_a0  in  1  clock; reset rst_main_n, asynchronous, active-low; clock clk_main_a0.
REQ-004 SHALL have port rst_main_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port group s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  in  ID_W/64/8/3/2  write address payload.
REQ-006 SHALL have port pair s_awvalid in 1 / s_awready out 1  AW handshake.
REQ-007 SHALL have port group s_wdata/s_wstrb/s_wlast  in  512/64/1  write data payload.
REQ-008 SHALL have port pair s_wvalid in 1 / s_wready out 1  W handshake.
REQ-009 SHALL have port group s_bid/s_bresp  out  ID_W/2  write response.
REQ-010 SHALL have port pair s_bvalid out 1 / s_bready in 1  B handshake.
REQ-011 SHALL have port group s_arid/s_araddr/s_arlen/s_arsize/s_arburst  in  ID_W/64/8/3/2  read address payload.
REQ-012 SHALL have port pair s_arvalid in 1 / s_arready out 1  AR handshake.
REQ-013 SHALL have port group s_rid/s_rdata/s_rresp/s_rlast  out  ID_W/512/2/1  read data payload.
REQ-014 SHALL have port pair s_rvalid out 1 / s_rready in 1  R handshake.

Function
REQ-015 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP.
- W_IDLE: awready=1; on the AW handshake it latches id, word index = awaddr[63:6], and len, clears the error flag, and moves to W_DATA.
REQ-016 W_DATA: wready=1; each handshake SHALL write the word at the current index with wstrb byte enables, increment the index, and increment the beat count.
- The beat with count==len SHALL end the burst and move to W_RESP.
REQ-017 The write error flag SHALL set on any of:
- awsize!=6 or awburst!=INCR;
- any beat whose index >= MEM_DEPTH; that beat is dropped with no memory write;
- wlast!=(count==len).
REQ-018 Burst length SHALL be governed by awlen alone; an early or missing wlast only sets the error flag.
REQ-019 W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if the error flag is set, else 2'b00; all held stable until bready; then W_IDLE.
REQ-020 Read FSM SHALL use states R_IDLE, R_FETCH, R_DATA and run independently of the write FSM.
- R_IDLE: arready=1; on the AR handshake it latches id, index, and len, then moves to R_FETCH.
REQ-021 R_FETCH SHALL issue one memory read (1-cycle latency) and move to R_DATA.
REQ-022 R_DATA: rvalid=1, rid=latched id, rlast=(count==arlen); rdata and rresp held stable until rready.
- On handshake: R_IDLE if last, else index+1 and R_FETCH.
- Minimum spacing is 2 cycles per beat.
REQ-023 A read beat with index >= MEM_DEPTH, arsize!=6, or arburst!=INCR SHALL return rdata=0 and rresp=2'b10; other beats return 2'b00.
REQ-024 Index arithmetic SHALL be 58-bit with no wrap; bursts running past MEM_DEPTH produce out-of-range beats.
REQ-025 Same-cycle read and write to one word SHALL return the old data (read-first).
REQ-026 Latency SHALL be:
- AW handshake to first wready: 1 cycle;
- last W beat to bvalid: 1 cycle;
- AR handshake to rvalid: 2 cycles.

Reset
REQ-027 Asserting rst_main_n low SHALL immediately force both FSMs to IDLE, awready=arready=0, wready=bvalid=rvalid=0, and all payload outputs and counters to 0.
- awready and arready rise to 1 on the first clk_main_a0 edge after deassertion.
REQ-028 Memory contents SHALL NOT be reset; reset mid-burst SHALL abandon the burst silently with no B or R response.

Structure
REQ-029 Package ddr_rsp_pkg SHALL hold:
- resp encodings OKAY=2'b00, SLVERR=2'b10;
- SIZE_64B=3'd6 and BURST_INCR=2'b01;
- wr_state_t and rd_state_t enums;
- data width 512 and strobe width 64.
REQ-030 The memory SHALL be the single sub-module ddr_rsp_mem: simple dual-port, 512-bit, 64 byte enables, read-first, 1-cycle registered read, no reset.

Verification
REQ-031 Write awaddr=0x40, awlen=3, strb all-ones, data D0..D3 with wlast on beat 3 -> words 1..4 written, then bresp=OKAY with bid echoed.
REQ-032 Read araddr=0x40, arlen=3 -> four beats D0..D3, rresp=OKAY, rlast only on beat 3, rid echoed.
REQ-033 Write with wstrb=0x0F over a known word -> only bytes 0..3 change on readback.
REQ-034 Write at awaddr=(MEM_DEPTH-1)*64, awlen=1 -> word MEM_DEPTH-1 written, second beat dropped, bresp=SLVERR; matching read -> beat0 OKAY, beat1 rdata=0 and rresp=SLVERR.
REQ-035 Hold bready=0 and rready=0 for 10 cycles -> bvalid, rvalid, and payloads stable; no new AW or AR accepted.
REQ-036 Assert reset during beat 2 of an 8-beat read with a concurrent write -> all outputs 0, no B/R, idle; awready=arready=1 after release.
